iomem_slave_mux: RTL
====================

# iomem_slave_mux

Upstream stage of the I/O peripheral bridges: accepts the CPU I/O memory bus and routes each transfer to one of `NUM_SLAVES` peripheral ports, such as the PWM/GPIO bridge at 0x3000_0000. It decodes the address, holds the selected slave's `valid` until `ready`, and returns read data to the CPU. It guarantees the CPU never hangs: out-of-window addresses and non-responding slaves complete with an error word and a sticky error flag.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports (1..8).
- `BASE_ADDR`, 32'h3000_0000: start of the decoded window.
- `SPAN_LOG2`, 8: log2 of the bytes per slave. Slave i covers BASE_ADDR + i·2^SPAN_LOG2.
- `TIMEOUT`, 64: maximum cycles `s_valid` stays high without `s_ready` (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `m_valid`  in  1  CPU request.
- `m_addr`  in  32  byte address.
- `m_wstrb`  in  4  write strobes (0 = read).
- `m_wdata`  in  32  write data.
- `m_rdata`  out  32  read data, valid while `m_ready` is high.
- `m_ready`  out  1  one-cycle completion pulse.
- `s_valid`  out  NUM_SLAVES  one-hot slave select.
- `s_addr`  out  32  latched address (full, not offset).
- `s_wstrb`  out  4  latched strobes.
- `s_wdata`  out  32  latched write data.
- `s_rdata`  in  32·NUM_SLAVES  concatenated slave read data; slave i in bits [32i+31:32i].
- `s_ready`  in  NUM_SLAVES  slave completion.
- `err_flag`  out  1  sticky error indication.
- `err_addr`  out  32  address of the most recent error.
- `err_clr`  in  1  clears `err_flag`.

## Operation
- FSM states: IDLE, ACCESS, RESP, ERR.
- **IDLE**, `m_valid` = 1:
  - Latch addr, wstrb and wdata into the `s_*` registers.
  - Compute idx = (m_addr − BASE_ADDR) >> SPAN_LOG2.
  - In window (m_addr ≥ BASE_ADDR and idx < NUM_SLAVES): go to ACCESS and set `s_valid[idx]`.
  - Otherwise: go to ERR.
  - Subtraction is 32-bit unsigned; the ≥ compare prevents wrap-around aliasing.
- **ACCESS**:
  - Timeout counter starts at 0 on entry and increments each cycle `s_ready[idx]` is low.
  - `s_ready[idx]` high: capture the idx slice of `s_rdata` into `m_rdata`, clear `s_valid`, go to RESP.
  - Counter = TIMEOUT−1 with `s_ready[idx]` low: clear `s_valid`, go to ERR.
  - `s_ready` and timeout in the same cycle: ready wins.
  - `s_ready` bits of unselected slaves are ignored.
- **RESP**: `m_ready` = 1 for this one cycle, then go to IDLE.
- **ERR**:
  - `m_rdata` = 32'hDEAD_BEEF for reads and writes; `m_ready` = 1 for one cycle.
  - Set `err_flag`; load `err_addr` with the latched address; go to IDLE.
- `err_clr` clears `err_flag` in any state. If a set and a clear land in the same cycle, set wins.
- `err_addr` holds until the next error.
- `m_valid` dropping mid-transfer (protocol violation) is ignored; the transfer completes normally.
- `m_rdata` for writes that complete normally is don't-care; the implementation loads the slave slice.

## Timing
- All outputs are registered.
- Reset values: `m_ready` 0, `m_rdata` 0, `s_valid` 0, `s_addr`/`s_wstrb`/`s_wdata` 0, `err_flag` 0, `err_addr` 0, FSM in IDLE, counter 0.
- Reset is asserted asynchronously and takes effect mid-transfer; no response is issued for the aborted access.
- Normal path, with edge E0 sampling `m_valid` in IDLE:
  - `s_valid` is high after E0.
  - A registered slave raises `s_ready` after E1.
  - The mux samples it at E2; `m_ready` is high after E2, so the CPU sees it at E3.
  - Minimum latency is 3 edges.
- Out-of-window path: `m_ready` is high after E1 (2 edges).
- Timeout path: `s_valid` is high for exactly TIMEOUT cycles, then `m_ready` goes high the cycle after `s_valid` falls.
- `s_valid` falls on the edge that samples `s_ready`. A registered slave may therefore see one extra valid cycle; slaves must tolerate a repeated idempotent access.
- The one-cycle `m_ready` pulse is followed by IDLE. A new `m_valid` is accepted on the edge after `m_ready` is deasserted, giving 1 idle cycle minimum between transfers.

## Structure
- Shared package/include `iomem_defs`:
  - FSM state encoding.
  - `IOMEM_ERR_RDATA` = 32'hDEAD_BEEF.
  - Default `BASE_ADDR` and `SPAN_LOG2` for the SoC memory map.
- One natural sub-module, `iomem_addr_decode`: purely combinational, producing idx and in_window from the address and parameters. It is reused by the future DMA port.
- FSM, timeout counter and data path stay in the top level.

## Test plan
- Read from 0x3000_0004, slave 0 returns 0x0000_1234 with registered ready → `s_valid` = 4'b0001 for 2 cycles, `m_rdata` = 0x0000_1234, `m_ready` pulse 3 edges after the request.
- Write 0xA5 with wstrb 4'hF to 0x3000_0208 (NUM_SLAVES = 4) → `s_valid` = 4'b0100, `s_addr` = 0x3000_0208, `s_wdata` = 0xA5, `err_flag` = 0.
- Read from 0x2FFF_FFFC, then from 0x3000_0400 → each completes in 2 edges with `m_rdata` = 0xDEAD_BEEF, `err_flag` = 1, `err_addr` = 0x3000_0400.
- Slave 1 never readies, TIMEOUT = 64 → `s_valid[1]` high for exactly 64 cycles, then a DEADBEEF response. Variant: ready arriving on cycle 64 wins, with no error.
- `err_clr` pulsed in the same cycle as a new error → `err_flag` stays 1. Pulsed alone → `err_flag` = 0.
- `resetn` asserted while in ACCESS → `s_valid`, `m_ready` and the counter are 0 immediately. After release, the next read completes normally.

Source files
------------

// File: rtl/iomem_defs.sv
// Shared definitions for the I/O memory bridge: FSM encoding, error word and
// the SoC default peripheral window.
package iomem_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } iomem_state_e;

    localparam logic [31:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] IOMEM_BASE_ADDR = 32'h3000_0000;
    localparam int          IOMEM_SPAN_LOG2 = 8;

endpackage

// File: rtl/iomem_addr_decode.sv
// Combinational window decoder: maps a byte address to a slave index and
// reports whether it falls inside the decoded window.
module iomem_addr_decode
    import iomem_defs::*;
#(
    parameter logic [31:0] BASE_ADDR  = IOMEM_BASE_ADDR,
    parameter int          SPAN_LOG2  = IOMEM_SPAN_LOG2,
    parameter int          NUM_SLAVES = 4,
    parameter int          IDX_W      = 2
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             in_window_o
);

    logic [31:0] offset;
    logic [31:0] slot;

    // The >= compare rejects addresses below the base whose offset wrapped.
    assign offset      = addr_i - BASE_ADDR;
    assign slot        = offset >> SPAN_LOG2;
    assign in_window_o = (addr_i >= BASE_ADDR) && (slot < 32'(NUM_SLAVES));
    assign idx_o       = slot[IDX_W-1:0];

endmodule

// File: rtl/iomem_slave_mux.sv
// CPU I/O bus to NUM_SLAVES peripheral ports: decodes, holds the slave valid
// until ready, and completes every transfer (error word on miss or timeout).
module iomem_slave_mux
    import iomem_defs::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = IOMEM_BASE_ADDR,
    parameter int          SPAN_LOG2  = IOMEM_SPAN_LOG2,
    parameter int          TIMEOUT    = 64,
    localparam int         IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int         CNT_W      = $clog2(TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic                     m_ready,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic                     err_flag,
    output logic [31:0]              err_addr,
    input  logic                     err_clr,
    output logic [1:0]               dbg_state,
    output logic [CNT_W-1:0]         dbg_cnt
);

    // Handshake: master holds m_valid until a one-cycle m_ready pulse; a slave
    // sees s_valid held until it raises s_ready, and s_valid drops on the edge
    // that samples s_ready, so slaves must tolerate one repeated access.

    iomem_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   m_ready_q, m_ready_d;
    logic [31:0]            m_rdata_q, m_rdata_d;
    logic [NUM_SLAVES-1:0]  s_valid_q, s_valid_d;
    logic [31:0]            s_addr_q, s_addr_d;
    logic [3:0]             s_wstrb_q, s_wstrb_d;
    logic [31:0]            s_wdata_q, s_wdata_d;
    logic                   err_flag_q, err_flag_d;
    logic [31:0]            err_addr_q, err_addr_d;

    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_in_window;
    logic [31:0]            sel_rdata;
    logic                   sel_ready;
    logic                   accept;
    logic                   timed_out;

    iomem_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .SPAN_LOG2  (SPAN_LOG2),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i      (m_addr),
        .idx_o       (dec_idx),
        .in_window_o (dec_in_window)
    );

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = s_rdata[32*i +: 32];
                sel_ready = s_ready[i];
            end
        end
    end

    // m_ready still high means the previous transfer's pulse is on the bus.
    assign accept    = (state_q == ST_IDLE) && m_valid && !m_ready_q;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = dec_in_window ? ST_ACCESS : ST_ERR;
            end
            ST_ACCESS: begin
                if (sel_ready)      state_d = ST_RESP;
                else if (timed_out) state_d = ST_ERR;
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        m_ready_d  = 1'b0;
        m_rdata_d  = m_rdata_q;
        s_valid_d  = s_valid_q;
        s_addr_d   = s_addr_q;
        s_wstrb_d  = s_wstrb_q;
        s_wdata_d  = s_wdata_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    s_addr_d  = m_addr;
                    s_wstrb_d = m_wstrb;
                    s_wdata_d = m_wdata;
                    idx_d     = dec_idx;
                    cnt_d     = '0;
                    if (dec_in_window) s_valid_d = NUM_SLAVES'(1) << dec_idx;
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    m_ready_d = 1'b1;
                    s_valid_d = '0;
                end else if (timed_out) begin
                    s_valid_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                m_rdata_d  = IOMEM_ERR_RDATA;
                m_ready_d  = 1'b1;
                err_addr_d = s_addr_q;
            end
            default: ;
        endcase
        // A new error outranks a simultaneous clear.
        if (state_q == ST_ERR) err_flag_d = 1'b1;
        else if (err_clr)      err_flag_d = 1'b0;
        else                   err_flag_d = err_flag_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            m_ready_q  <= 1'b0;
            m_rdata_q  <= '0;
            s_valid_q  <= '0;
            s_addr_q   <= '0;
            s_wstrb_q  <= '0;
            s_wdata_q  <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            s_valid_q  <= s_valid_d;
            s_addr_q   <= s_addr_d;
            s_wstrb_q  <= s_wstrb_d;
            s_wdata_q  <= s_wdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wstrb   = s_wstrb_q;
    assign s_wdata   = s_wdata_q;
    assign err_flag  = err_flag_q;
    assign err_addr  = err_addr_q;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule
